gcn_combination_engine: RTL and testbench

Parametrised successor to the GCN combination stage. It accepts a COO edge list over a valid/ready handshake and builds the adjacency matrix internally. Optionally it symmetrises the graph and adds self-loops. It then computes ADJ × (FM·WM) row by row into a widened result memory, and produces a per-row argmax class index. It sits after the FM·WM product memory, which it reads through its own row-address port, and feeds the classification output.

---
 rtl/gcn_combination_engine_if.sv | 33 +++
 rtl/gcn_combination_engine.sv | 155 +++++++++++++++
 tb/tb_gcn_combination_engine.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/gcn_combination_engine_if.sv
// Handshake, FM*WM read port and result bus of the GCN combination engine.
// The engine takes the slave side; the upstream/downstream environment takes the master side.
interface gcn_combination_engine_if #(
  parameter int unsigned NUM_OF_NODES      = 6,
  parameter int unsigned WEIGHT_COLS       = 3,
  parameter int unsigned DOT_PROD_WIDTH    = 16,
  parameter int unsigned ACC_WIDTH         = DOT_PROD_WIDTH + $clog2(NUM_OF_NODES + 1),
  parameter int unsigned NODE_BW           = $clog2(NUM_OF_NODES),
  parameter int unsigned MAX_ADDRESS_WIDTH = $clog2(WEIGHT_COLS)
);
  logic                                          start;
  logic                                          coo_valid;
  logic [NODE_BW-1:0]                            coo_src;
  logic [NODE_BW-1:0]                            coo_dst;
  logic                                          coo_ready;
  logic [NODE_BW-1:0]                            fm_wm_read_row;
  logic [WEIGHT_COLS*DOT_PROD_WIDTH-1:0]         fm_wm_row;
  logic [NUM_OF_NODES*WEIGHT_COLS*ACC_WIDTH-1:0] fm_wm_adj_out;
  logic [NUM_OF_NODES*MAX_ADDRESS_WIDTH-1:0]     max_addi_answer;
  logic                                          busy;
  logic                                          err;
  logic                                          done;

  modport master (
    output start, coo_valid, coo_src, coo_dst, fm_wm_row,
    input  coo_ready, fm_wm_read_row, fm_wm_adj_out, max_addi_answer, busy, err, done
  );

  modport slave (
    input  start, coo_valid, coo_src, coo_dst, fm_wm_row,
    output coo_ready, fm_wm_read_row, fm_wm_adj_out, max_addi_answer, busy, err, done
  );
endinterface

// File: rtl/gcn_combination_engine.sv
// GCN combination stage: loads a COO edge list into an adjacency matrix, then computes
// ADJ x (FM*WM) one row per NUM_OF_NODES cycles with a per-row argmax.
module gcn_combination_engine #(
  parameter int unsigned NUM_OF_NODES      = 6,
  parameter int unsigned NUM_OF_EDGES      = 6,
  parameter int unsigned WEIGHT_COLS       = 3,
  parameter int unsigned DOT_PROD_WIDTH    = 16,
  parameter int unsigned ACC_WIDTH         = DOT_PROD_WIDTH + $clog2(NUM_OF_NODES + 1),
  parameter int unsigned NODE_BW           = $clog2(NUM_OF_NODES),
  parameter int unsigned MAX_ADDRESS_WIDTH = $clog2(WEIGHT_COLS),
  parameter int unsigned UNDIRECTED        = 0,
  parameter int unsigned ADD_SELF_LOOPS    = 0
) (
  input logic                     clk,
  input logic                     reset,
  gcn_combination_engine_if.slave if_bus
);
  localparam int unsigned EdgeCntW = $clog2(NUM_OF_EDGES + 1);

  typedef enum logic [2:0] {StIdle, StClear, StLoad, StCompute, StDone} state_e;

  state_e                                        r_state;
  logic [NUM_OF_NODES-1:0]                       r_adj [NUM_OF_NODES];
  logic [EdgeCntW-1:0]                           r_edge_cnt;
  logic [NODE_BW-1:0]                            r_i;
  logic [NODE_BW-1:0]                            r_j;
  logic [ACC_WIDTH-1:0]                          r_acc [WEIGHT_COLS];
  logic [NUM_OF_NODES*WEIGHT_COLS*ACC_WIDTH-1:0] r_adj_out;
  logic [NUM_OF_NODES*MAX_ADDRESS_WIDTH-1:0]     r_argmax;
  logic                                          r_coo_ready;
  logic                                          r_busy;
  logic                                          r_err;
  logic                                          r_done;

  logic [ACC_WIDTH-1:0]         w_sum [WEIGHT_COLS];
  logic [ACC_WIDTH-1:0]         w_best_val;
  logic [MAX_ADDRESS_WIDTH-1:0] w_best_idx;
  logic                         w_hit;
  logic                         w_edge_ok;
  logic                         w_row_end;
  logic                         w_last_row;

  // Strict '>' scanning upward keeps the lowest column on ties.
  always_comb begin
    w_hit = r_adj[r_i][r_j];
    for (int c = 0; c < WEIGHT_COLS; c++) begin
      w_sum[c] = r_acc[c] + (w_hit ?
          ACC_WIDTH'(if_bus.fm_wm_row[c*DOT_PROD_WIDTH +: DOT_PROD_WIDTH]) : '0);
    end
    w_best_val = w_sum[0];
    w_best_idx = '0;
    for (int c = 1; c < WEIGHT_COLS; c++) begin
      if (w_sum[c] > w_best_val) begin
        w_best_val = w_sum[c];
        w_best_idx = MAX_ADDRESS_WIDTH'(c);
      end
    end
  end

  assign w_edge_ok  = (32'(if_bus.coo_src) < NUM_OF_NODES) && (32'(if_bus.coo_dst) < NUM_OF_NODES);
  assign w_row_end  = (r_j == NODE_BW'(NUM_OF_NODES - 1));
  assign w_last_row = (r_i == NODE_BW'(NUM_OF_NODES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= StIdle;
      for (int k = 0; k < NUM_OF_NODES; k++) r_adj[k] <= '0;
      r_edge_cnt  <= '0;
      r_i         <= '0;
      r_j         <= '0;
      for (int c = 0; c < WEIGHT_COLS; c++) r_acc[c] <= '0;
      r_adj_out   <= '0;
      r_argmax    <= '0;
      r_coo_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (if_bus.start) begin
            r_state <= StClear;
            r_busy  <= 1'b1;
          end
        end
        StClear: begin
          for (int k = 0; k < NUM_OF_NODES; k++) begin
            for (int m = 0; m < NUM_OF_NODES; m++) begin
              r_adj[k][m] <= (ADD_SELF_LOOPS != 0) && (k == m);
            end
          end
          r_adj_out   <= '0;
          r_argmax    <= '0;
          r_err       <= 1'b0;
          r_edge_cnt  <= '0;
          r_coo_ready <= 1'b1;
          r_state     <= StLoad;
        end
        StLoad: begin
          // Out-of-range edges still count toward NUM_OF_EDGES; they only flag err.
          if (if_bus.coo_valid) begin
            if (w_edge_ok) begin
              r_adj[if_bus.coo_src][if_bus.coo_dst] <= 1'b1;
              if (UNDIRECTED != 0) r_adj[if_bus.coo_dst][if_bus.coo_src] <= 1'b1;
            end else begin
              r_err <= 1'b1;
            end
            if (r_edge_cnt == EdgeCntW'(NUM_OF_EDGES - 1)) begin
              r_edge_cnt  <= '0;
              r_coo_ready <= 1'b0;
              r_state     <= StCompute;
            end else begin
              r_edge_cnt <= r_edge_cnt + 1'b1;
            end
          end
        end
        StCompute: begin
          if (w_row_end) begin
            for (int c = 0; c < WEIGHT_COLS; c++) begin
              r_adj_out[(int'(r_i)*WEIGHT_COLS + c)*ACC_WIDTH +: ACC_WIDTH] <= w_sum[c];
              r_acc[c] <= '0;
            end
            r_argmax[int'(r_i)*MAX_ADDRESS_WIDTH +: MAX_ADDRESS_WIDTH] <= w_best_idx;
            r_j <= '0;
            if (w_last_row) begin
              r_i     <= '0;
              r_done  <= 1'b1;
              r_state <= StDone;
            end else begin
              r_i <= r_i + 1'b1;
            end
          end else begin
            for (int c = 0; c < WEIGHT_COLS; c++) r_acc[c] <= w_sum[c];
            r_j <= r_j + 1'b1;
          end
        end
        StDone: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // r_j rests at 0 outside COMPUTE, so it doubles as the read address.
  assign if_bus.coo_ready       = r_coo_ready;
  assign if_bus.fm_wm_read_row  = r_j;
  assign if_bus.fm_wm_adj_out   = r_adj_out;
  assign if_bus.max_addi_answer = r_argmax;
  assign if_bus.busy            = r_busy;
  assign if_bus.err             = r_err;
  assign if_bus.done            = r_done;
endmodule

// File: tb/tb_gcn_combination_engine.sv
// Bench for gcn_combination_engine: three parameter variants share one edge stream;
// a graph model fills a scoreboard that is drained when the run finishes.
module tb_gcn_combination_engine;
  localparam int unsigned N   = 6;
  localparam int unsigned E   = 6;
  localparam int unsigned WC  = 3;
  localparam int unsigned DW  = 16;
  localparam int unsigned AW  = DW + $clog2(N + 1);
  localparam int unsigned NBW = $clog2(N);
  localparam int unsigned MAW = $clog2(WC);

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic           coo_valid = 1'b0;
  logic [NBW-1:0] coo_src = '0;
  logic [NBW-1:0] coo_dst = '0;

  always #5 clk = ~clk;

  gcn_combination_engine_if #(.NUM_OF_NODES(N), .WEIGHT_COLS(WC), .DOT_PROD_WIDTH(DW)) if_a ();
  gcn_combination_engine_if #(.NUM_OF_NODES(N), .WEIGHT_COLS(WC), .DOT_PROD_WIDTH(DW)) if_u ();
  gcn_combination_engine_if #(.NUM_OF_NODES(N), .WEIGHT_COLS(WC), .DOT_PROD_WIDTH(DW)) if_s ();

  function automatic logic [WC*DW-1:0] ramp_row(input logic [NBW-1:0] j);
    logic [DW-1:0] v;
    v = DW'(j) + DW'(1);
    return {DW'(0), DW'(v << 1), v};
  endfunction

  assign if_a.start = start;  assign if_a.coo_valid = coo_valid;
  assign if_a.coo_src = coo_src;  assign if_a.coo_dst = coo_dst;
  assign if_u.start = start;  assign if_u.coo_valid = coo_valid;
  assign if_u.coo_src = coo_src;  assign if_u.coo_dst = coo_dst;
  assign if_s.start = start;  assign if_s.coo_valid = coo_valid;
  assign if_s.coo_src = coo_src;  assign if_s.coo_dst = coo_dst;
  assign if_a.fm_wm_row = ramp_row(if_a.fm_wm_read_row);
  assign if_u.fm_wm_row = ramp_row(if_u.fm_wm_read_row);
  assign if_s.fm_wm_row = '1;

  gcn_combination_engine #(.NUM_OF_NODES(N), .NUM_OF_EDGES(E), .WEIGHT_COLS(WC),
    .DOT_PROD_WIDTH(DW), .UNDIRECTED(0), .ADD_SELF_LOOPS(0))
    dut_a (.clk(clk), .reset(reset), .if_bus(if_a));
  gcn_combination_engine #(.NUM_OF_NODES(N), .NUM_OF_EDGES(E), .WEIGHT_COLS(WC),
    .DOT_PROD_WIDTH(DW), .UNDIRECTED(1), .ADD_SELF_LOOPS(0))
    dut_u (.clk(clk), .reset(reset), .if_bus(if_u));
  gcn_combination_engine #(.NUM_OF_NODES(N), .NUM_OF_EDGES(E), .WEIGHT_COLS(WC),
    .DOT_PROD_WIDTH(DW), .UNDIRECTED(1), .ADD_SELF_LOOPS(1))
    dut_s (.clk(clk), .reset(reset), .if_bus(if_s));

  typedef struct {
    int     dut;
    int     row;
    int     col;     // col == WC selects the argmax entry
    longint val;
  } exp_t;

  exp_t sb[$];
  int   ev_src[E];
  int   ev_dst[E];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input longint obs, input longint exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint fm_val(input int d, input int j, input int c);
    if (d == 2) return 65535;
    if (c == 0) return j + 1;
    if (c == 1) return 2 * (j + 1);
    return 0;
  endfunction

  function automatic longint actual(input int d, input int r, input int c);
    logic [N*WC*AW-1:0] o;
    logic [N*MAW-1:0]   m;
    case (d)
      0:       begin o = if_a.fm_wm_adj_out; m = if_a.max_addi_answer; end
      1:       begin o = if_u.fm_wm_adj_out; m = if_u.max_addi_answer; end
      default: begin o = if_s.fm_wm_adj_out; m = if_s.max_addi_answer; end
    endcase
    if (c == WC) return longint'(m[r*MAW +: MAW]);
    return longint'(o[(r*WC + c)*AW +: AW]);
  endfunction

  // Graph model: adjacency from the edge list, then plain matrix product and argmax.
  task automatic push_expected();
    bit     adj[N][N];
    longint sum;
    longint best;
    int     best_c;
    exp_t   e;
    for (int d = 0; d < 3; d++) begin
      for (int a = 0; a < N; a++)
        for (int b = 0; b < N; b++) adj[a][b] = (d == 2) && (a == b);
      for (int k = 0; k < E; k++) begin
        if (ev_src[k] < N && ev_dst[k] < N) begin
          adj[ev_src[k]][ev_dst[k]] = 1'b1;
          if (d >= 1) adj[ev_dst[k]][ev_src[k]] = 1'b1;
        end
      end
      for (int i = 0; i < N; i++) begin
        best = -1;
        best_c = 0;
        for (int c = 0; c < WC; c++) begin
          sum = 0;
          for (int j = 0; j < N; j++) if (adj[i][j]) sum += fm_val(d, j, c);
          if (sum > best) begin best = sum; best_c = c; end
          e.dut = d; e.row = i; e.col = c; e.val = sum;
          sb.push_back(e);
        end
        e.dut = d; e.row = i; e.col = WC; e.val = best_c;
        sb.push_back(e);
      end
    end
  endtask

  task automatic drain_sb();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check($sformatf("dut%0d_row%0d_col%0d", e.dut, e.row, e.col),
            actual(e.dut, e.row, e.col), e.val);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_ready"}, longint'(if_a.coo_ready), 0);
    check({tag, "_busy"}, longint'(if_a.busy), 0);
    check({tag, "_done"}, longint'(if_a.done), 0);
    check({tag, "_err"}, longint'(if_a.err), 0);
    check({tag, "_rdrow"}, longint'(if_a.fm_wm_read_row), 0);
    check({tag, "_out"}, longint'(if_a.fm_wm_adj_out == '0), 1);
    check({tag, "_argmax"}, longint'(if_a.max_addi_answer == '0), 1);
  endtask

  task automatic set_ring();
    for (int k = 0; k < E; k++) begin
      ev_src[k] = k;
      ev_dst[k] = (k + 1) % N;
    end
  endtask

  // poke_cyc < 0: no poke; otherwise start (or reset) is driven across edge poke_cyc.
  task automatic run(input bit bp, input int poke_cyc, input bit poke_reset);
    int done_cnt;
    int done_cyc;
    int exp_done;
    done_cnt = 0;
    done_cyc = 0;
    exp_done = bp ? 2 + 2 * E + N * N : 2 + E + N * N;
    cyc = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("clear_busy", longint'(if_a.busy), 1);
    check("clear_ready", longint'(if_a.coo_ready), 0);
    tick();
    check("load_ready", longint'(if_a.coo_ready), 1);
    check("load_err_cleared", longint'(if_a.err), 0);
    push_expected();
    for (int k = 0; k < E; k++) begin
      if (bp) begin
        coo_valid = 1'b0;
        coo_src = NBW'(7);
        coo_dst = NBW'(7);
        tick();
        check("bp_ready_held", longint'(if_a.coo_ready), 1);
      end
      coo_valid = 1'b1;
      coo_src = NBW'(ev_src[k]);
      coo_dst = NBW'(ev_dst[k]);
      tick();
    end
    coo_valid = 1'b0;
    check("load_end_ready", longint'(if_a.coo_ready), 0);
    check("load_end_err", longint'(if_a.err), longint'(bp));
    while (cyc < 60) begin
      if (cyc == poke_cyc) begin
        if (poke_reset) reset = 1'b1;
        else start = 1'b1;
      end
      tick();
      reset = 1'b0;
      start = 1'b0;
      if (poke_cyc >= 0 && cyc == poke_cyc + 1) begin
        if (poke_reset) begin
          check_idle_zero("midreset");
          sb.delete();
          return;
        end
        check("start_ignored_ready", longint'(if_a.coo_ready), 0);
        check("start_ignored_busy", longint'(if_a.busy), 1);
      end
      if (!bp && cyc == 2 + E + N) begin
        check("row0_visible", actual(0, 0, 1), 4);
        check("row1_not_yet", actual(0, 1, 1), 0);
      end
      if (if_a.done) begin
        done_cnt++;
        done_cyc = cyc;
        check("done_err", longint'(if_a.err), longint'(bp));
        check("done_busy", longint'(if_a.busy), 1);
      end
    end
    check("done_count", done_cnt, 1);
    check("done_cycle", done_cyc, exp_done);
    check("post_busy", longint'(if_a.busy), 0);
    check("post_err_held", longint'(if_a.err), longint'(bp));
    drain_sb();
  endtask

  initial begin
    reset = 1'b1;
    repeat (2) tick();
    check_idle_zero("reset");
    reset = 1'b0;
    tick();

    set_ring();
    run(1'b0, -1, 1'b0);
    check("ring_row0_c0", actual(0, 0, 0), 2);
    check("ring_row0_c1", actual(0, 0, 1), 4);
    check("ring_row5_c0", actual(0, 5, 0), 1);
    check("ring_row5_c1", actual(0, 5, 1), 2);
    check("ring_argmax3", actual(0, 3, WC), 1);
    check("undir_row0_c0", actual(1, 0, 0), 8);
    check("undir_row3_c1", actual(1, 3, 1), 16);
    check("self_row2_c2", actual(2, 2, 2), 196605);
    check("self_argmax4", actual(2, 4, WC), 0);

    ev_src[0] = 0; ev_dst[0] = 1;
    ev_src[1] = 0; ev_dst[1] = 1;
    ev_src[2] = 7; ev_dst[2] = 2;
    ev_src[3] = 2; ev_dst[3] = 3;
    ev_src[4] = 3; ev_dst[4] = 4;
    ev_src[5] = 4; ev_dst[5] = 5;
    run(1'b1, -1, 1'b0);
    check("bp_row0_c0_once", actual(0, 0, 0), 2);
    check("bp_row1_c1_empty", actual(0, 1, 1), 0);

    set_ring();
    run(1'b0, 20, 1'b0);
    run(1'b0, 25, 1'b1);
    run(1'b0, -1, 1'b0);
    check("fresh_row0_c1", actual(0, 0, 1), 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, required run completion");
    $fatal(1, "watchdog expired");
  end
endmodule
